decoder_ctrl: RTL and testbench

DECODER_CTRL -- requirements
Module: decoder_ctrl

---
 rtl/decoder_pkg.sv | 23 ++
 rtl/decoder_ctrl_enable_pipe.sv | 33 +++
 rtl/decoder_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_decoder_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and constants for the Viterbi decoder control path.
package decoder_pkg;

   localparam logic CODE_RATE_2 = 1'b0;
   localparam logic CODE_RATE_3 = 1'b1;

   localparam int unsigned TB_DEPTH_DEF = 16;
   localparam int unsigned FRAME_W      = 16;
   localparam int unsigned NFRAME_W     = 8;
   localparam int unsigned SYM_W        = 8;
   localparam int unsigned STEP_W       = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ALIGN,
      ST_SLICE,
      ST_DRAIN,
      ST_TB,
      ST_DONE
   } state_e;

endpackage

// File: rtl/decoder_ctrl_enable_pipe.sv
// Two-stage delay line: slicer enable -> branch-metric enable -> ACS enable.
module enable_pipe (
   input  logic clk,
   input  logic rst,
   input  logic en_in,
   output logic en_d1,
   output logic en_d2
);

   logic s1_d, s1_q;
   logic s2_d, s2_q;

   // Next-stage values: each stage copies the one before it
   always_comb begin
      s1_d = en_in;
      s2_d = s1_q;
   end

   // Delay registers, cleared on the same edge as the controller
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign en_d1 = s1_q;
   assign en_d2 = s2_q;

endmodule

// File: rtl/decoder_ctrl.sv
// Decoder job sequencer: fetches frames, drives slicer/BM/ACS enables and
// schedules traceback runs every TB_DEPTH symbols plus a final flush.
module decoder_ctrl
   import decoder_pkg::*;
#(
   parameter int unsigned TB_DEPTH = TB_DEPTH_DEF,
   parameter int unsigned STEPS_R2 = 4,
   parameter int unsigned STEPS_R3 = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   input  logic                i_code_rate,
   input  logic [NFRAME_W-1:0] i_num_frames,
   input  logic                i_frame_valid,
   input  logic [FRAME_W-1:0]  i_data_frame,
   input  logic                i_tb_done,
   output logic                o_frame_req,
   output logic [FRAME_W-1:0]  o_data_frame,
   output logic                o_code_rate,
   output logic                o_slice_rst,
   output logic                en_s,
   output logic                en_bm,
   output logic                en_acs,
   output logic                o_tb_start,
   output logic                o_busy,
   output logic                o_done
);

   localparam logic [STEP_W-1:0] R2_LAST  = STEP_W'(STEPS_R2 - 1);
   localparam logic [STEP_W-1:0] R3_LAST  = STEP_W'(STEPS_R3 - 1);
   localparam logic [SYM_W-1:0]  TB_DEP_S = SYM_W'(TB_DEPTH);
   localparam logic [SYM_W-1:0]  SYM_INC  = SYM_W'(2);

   state_e               state_d, state_q;
   logic [STEP_W-1:0]    step_d, step_q;
   logic [NFRAME_W-1:0]  frames_d, frames_q;
   logic [SYM_W-1:0]     sym_d, sym_q;
   logic [SYM_W-1:0]     sym_sum;
   logic [STEP_W-1:0]    step_last;
   logic                 rate_d, rate_q;
   logic [FRAME_W-1:0]   data_d, data_q;
   logic                 frame_req_d, frame_req_q;
   logic                 slice_rst_d, slice_rst_q;
   logic                 en_s_d, en_s_q;
   logic                 tb_start_d, tb_start_q;
   logic                 busy_d, busy_q;
   logic                 done_d, done_q;

   // Next state, counters and registered output values
   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      frames_d   = frames_q;
      rate_d     = rate_q;
      data_d     = data_q;
      tb_start_d = 1'b0;
      step_last  = (rate_q == CODE_RATE_3) ? R3_LAST : R2_LAST;
      // running symbol total including the ACS cycle in progress
      sym_sum    = sym_q + (en_acs ? SYM_INC : '0);
      sym_d      = sym_sum;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               rate_d   = i_code_rate;
               frames_d = i_num_frames;
               state_d  = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (i_frame_valid) begin
               data_d   = i_data_frame;
               frames_d = frames_q - NFRAME_W'(1);
               state_d  = ST_ALIGN;
            end
         end
         ST_ALIGN: begin
            step_d  = '0;
            state_d = ST_SLICE;
         end
         ST_SLICE: begin
            if (step_q == step_last) begin
               step_d  = '0;
               state_d = ST_DRAIN;
            end else begin
               step_d = step_q + STEP_W'(1);
            end
         end
         ST_DRAIN: begin
            if (step_q == STEP_W'(1)) begin
               step_d = '0;
               if (sym_sum >= TB_DEP_S) begin
                  sym_d      = sym_sum - TB_DEP_S;
                  tb_start_d = 1'b1;
                  state_d    = ST_TB;
               end else if (frames_q != '0) begin
                  state_d = ST_FETCH;
               end else if (sym_sum != '0) begin
                  sym_d      = '0;
                  tb_start_d = 1'b1;
                  state_d    = ST_TB;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               step_d = step_q + STEP_W'(1);
            end
         end
         ST_TB: begin
            if (i_tb_done) begin
               if (frames_q != '0) begin
                  state_d = ST_FETCH;
               end else if (sym_q != '0) begin
                  sym_d      = (sym_q >= TB_DEP_S) ? (sym_q - TB_DEP_S) : '0;
                  tb_start_d = 1'b1;
                  state_d    = ST_TB;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      frame_req_d = (state_d == ST_FETCH);
      slice_rst_d = (state_d != ST_ALIGN);
      en_s_d      = (state_d == ST_SLICE);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
   end

   // State, counters and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         step_q      <= '0;
         frames_q    <= '0;
         sym_q       <= '0;
         rate_q      <= 1'b0;
         data_q      <= '0;
         frame_req_q <= 1'b0;
         slice_rst_q <= 1'b1;
         en_s_q      <= 1'b0;
         tb_start_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         frames_q    <= frames_d;
         sym_q       <= sym_d;
         rate_q      <= rate_d;
         data_q      <= data_d;
         frame_req_q <= frame_req_d;
         slice_rst_q <= slice_rst_d;
         en_s_q      <= en_s_d;
         tb_start_q  <= tb_start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   enable_pipe u_enable_pipe (
      .clk   (clk),
      .rst   (rst),
      .en_in (en_s_q),
      .en_d1 (en_bm),
      .en_d2 (en_acs)
   );

   assign o_frame_req  = frame_req_q;
   assign o_data_frame = data_q;
   assign o_code_rate  = rate_q;
   assign o_slice_rst  = slice_rst_q;
   assign en_s         = en_s_q;
   assign o_tb_start   = tb_start_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;

endmodule

// File: tb/tb_decoder_ctrl.sv
// Scoreboard bench for decoder_ctrl: job-level model predicts the sequence of
// slice runs, traceback triggers and completion; a monitor checks the DUT.
module tb_decoder_ctrl;
   import decoder_pkg::*;

   localparam int D   = 16;
   localparam int SR2 = 4;
   localparam int SR3 = 2;
   localparam int EV_RUN  = 0;
   localparam int EV_TB   = 1;
   localparam int EV_DONE = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_start = 1'b0;
   logic        i_code_rate = 1'b0;
   logic [7:0]  i_num_frames = 8'd0;
   logic        i_frame_valid;
   logic [15:0] i_data_frame;
   logic        i_tb_done;
   logic        o_frame_req;
   logic [15:0] o_data_frame;
   logic        o_code_rate;
   logic        o_slice_rst;
   logic        en_s, en_bm, en_acs;
   logic        o_tb_start, o_busy, o_done;

   always #5 clk = ~clk;

   decoder_ctrl #(.TB_DEPTH(D), .STEPS_R2(SR2), .STEPS_R3(SR3)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_code_rate(i_code_rate),
      .i_num_frames(i_num_frames), .i_frame_valid(i_frame_valid),
      .i_data_frame(i_data_frame), .i_tb_done(i_tb_done),
      .o_frame_req(o_frame_req), .o_data_frame(o_data_frame),
      .o_code_rate(o_code_rate), .o_slice_rst(o_slice_rst),
      .en_s(en_s), .en_bm(en_bm), .en_acs(en_acs),
      .o_tb_start(o_tb_start), .o_busy(o_busy), .o_done(o_done)
   );

   logic [31:0] exp_q[$];
   logic [15:0] frame_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int hold_next = 0;
   bit spurious_tb = 1'b0;
   logic rst_s;

   always @(posedge clk) rst_s <= rst;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] pack_ev(input int kind, input int len,
                                           input logic [15:0] data, input logic rate);
      return {5'd0, 2'(kind), rate, 8'(len), data};
   endfunction

   task automatic got_event(input logic [31:0] ev);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_event: got %08h required none at %0t", ev, $time);
      end else begin
         e = exp_q.pop_front();
         check("event", ev, e);
      end
   endtask

   // Monitor: samples on the falling edge, pops expectations on each DUT event
   logic        h1 = 1'b0, h2 = 1'b0;
   logic        prev_req = 1'b0, prev_valid = 1'b0, prev_srst = 1'b1, prev_done = 1'b0;
   logic [15:0] prev_data = '0;
   int          run_len = 0;
   logic [15:0] run_data = '0;
   logic        run_rate = 1'b0;

   always @(negedge clk) begin
      if (rst_s !== 1'b1) begin
         check("reset_values",
               {o_frame_req, o_slice_rst, en_s, en_bm, en_acs, o_tb_start, o_busy, o_done,
                o_code_rate, o_data_frame},
               {8'b0100_0000, 1'b0, 16'h0000});
         h1 = 1'b0; h2 = 1'b0; run_len = 0;
         prev_req = 1'b0; prev_valid = 1'b0; prev_srst = 1'b1; prev_done = 1'b0;
      end else begin
         check("en_bm_delay", en_bm, h1);
         check("en_acs_delay", en_acs, h2);
         if (prev_req && prev_valid) begin
            check("frame_req_drop", o_frame_req, 0);
            check("frame_latch", o_data_frame, prev_data);
         end else if (prev_req) begin
            check("frame_req_hold", o_frame_req, 1);
         end
         if (o_frame_req || !o_slice_rst || o_done)
            check("quiet_enables", {en_s, en_bm, en_acs, o_tb_start}, 0);
         if (o_frame_req || en_s || o_tb_start)
            check("busy_when_active", o_busy, 1);
         if (en_s) begin
            if (run_len == 0) begin
               check("align_before_slice", prev_srst, 0);
               run_data = o_data_frame;
               run_rate = o_code_rate;
            end
            run_len++;
         end else if (run_len != 0) begin
            got_event(pack_ev(EV_RUN, run_len, run_data, run_rate));
            run_len = 0;
         end
         if (o_tb_start) got_event(pack_ev(EV_TB, 0, 16'h0, 1'b0));
         if (o_done) begin
            got_event(pack_ev(EV_DONE, 0, 16'h0, 1'b0));
            done_cnt++;
            check("busy_in_done", o_busy, 1);
         end
         if (prev_done) check("idle_after_done", o_busy, 0);
         h2 = h1;
         h1 = en_s;
         prev_req   = o_frame_req;
         prev_valid = i_frame_valid;
         prev_data  = i_data_frame;
         prev_srst  = o_slice_rst;
         prev_done  = o_done;
      end
   end

   // Frame source: answers each request after a random or forced delay
   initial begin : frame_source
      int          wait_cnt;
      bit          req_prev;
      logic [15:0] dummy;
      wait_cnt = 0;
      req_prev = 1'b0;
      i_frame_valid = 1'b0;
      i_data_frame = '0;
      forever begin
         @(posedge clk); #1;
         if (rst_s !== 1'b1) begin
            i_frame_valid = 1'b0;
            req_prev = 1'b0;
         end else begin
            if (i_frame_valid && req_prev) begin
               i_frame_valid = 1'b0;
               if (frame_q.size() > 0) dummy = frame_q.pop_front();
            end
            if (o_frame_req && !req_prev) begin
               wait_cnt = (hold_next > 0) ? hold_next : int'($urandom_range(0, 3));
               hold_next = 0;
            end
            if (o_frame_req && !i_frame_valid) begin
               if (wait_cnt > 0) wait_cnt--;
               else if (frame_q.size() > 0) begin
                  i_frame_valid = 1'b1;
                  i_data_frame = frame_q[0];
               end
            end
            req_prev = o_frame_req;
         end
      end
   end

   // Traceback unit stand-in: completes 0..4 cycles after each trigger
   initial begin : tb_responder
      int tb_wait;
      bit tb_pending;
      tb_wait = 0;
      tb_pending = 1'b0;
      i_tb_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         i_tb_done = 1'b0;
         if (rst_s !== 1'b1) begin
            tb_pending = 1'b0;
         end else begin
            if (o_tb_start) begin
               tb_wait = int'($urandom_range(0, 4));
               tb_pending = 1'b1;
            end
            if (spurious_tb) begin
               i_tb_done = 1'b1;
               spurious_tb = 1'b0;
            end else if (tb_pending) begin
               if (tb_wait == 0) begin
                  i_tb_done = 1'b1;
                  tb_pending = 1'b0;
               end else begin
                  tb_wait--;
               end
            end
         end
      end
   end

   // Job model: slice runs per frame, traceback whenever TB_DEPTH symbols
   // accumulate, a flush traceback for any leftover, then one completion
   task automatic build_job(input logic rate, input int nframes,
                            input bit fixed_first, input logic [15:0] first_data);
      int          sym;
      int          steps;
      logic [15:0] d;
      steps = rate ? SR3 : SR2;
      sym = 0;
      for (int f = 0; f < nframes; f++) begin
         d = (f == 0 && fixed_first) ? first_data : 16'($urandom);
         frame_q.push_back(d);
         exp_q.push_back(pack_ev(EV_RUN, steps, d, rate));
         sym += 2 * steps;
         if (sym >= D) begin
            exp_q.push_back(pack_ev(EV_TB, 0, 16'h0, 1'b0));
            sym -= D;
         end else if (f == nframes - 1 && sym > 0) begin
            exp_q.push_back(pack_ev(EV_TB, 0, 16'h0, 1'b0));
            sym = 0;
         end
      end
      while (sym > 0) begin
         exp_q.push_back(pack_ev(EV_TB, 0, 16'h0, 1'b0));
         sym = (sym >= D) ? sym - D : 0;
      end
      exp_q.push_back(pack_ev(EV_DONE, 0, 16'h0, 1'b0));
   endtask

   task automatic pulse_start(input logic rate, input int nframes);
      @(posedge clk); #1;
      i_start = 1'b1;
      i_code_rate = rate;
      i_num_frames = 8'(nframes);
      @(posedge clk); #1;
      i_start = 1'b0;
      i_code_rate = 1'($urandom);
      i_num_frames = 8'($urandom);
   endtask

   task automatic wait_en_s();
      for (int c = 0; c < 400 && en_s !== 1'b1; c++) begin
         @(posedge clk); #1;
      end
      check("saw_en_s", en_s, 1);
   endtask

   task automatic run_job(input logic rate, input int nframes, input int hold,
                          input bit inject, input bit fixed_first, input logic [15:0] first_data);
      int start_done;
      start_done = done_cnt;
      build_job(rate, nframes, fixed_first, first_data);
      hold_next = hold;
      pulse_start(rate, nframes);
      if (inject) begin
         wait_en_s();
         i_start = 1'b1;
         i_code_rate = ~rate;
         i_num_frames = 8'd1;
         spurious_tb = 1'b1;
         @(posedge clk); #1;
         i_start = 1'b0;
      end
      for (int c = 0; c < 20000 && done_cnt == start_done; c++) @(posedge clk);
      repeat (6) @(posedge clk);
      #1;
      check("done_once", 32'(done_cnt - start_done), 1);
      check("events_left", 32'(exp_q.size()), 0);
      check("frames_left", 32'(frame_q.size()), 0);
      exp_q.delete();
      frame_q.delete();
   endtask

   task automatic abort_job();
      int start_done;
      start_done = done_cnt;
      build_job(CODE_RATE_2, 3, 1'b0, 16'h0);
      pulse_start(CODE_RATE_2, 3);
      wait_en_s();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      frame_q.delete();
      check("abort_outputs",
            {o_frame_req, o_slice_rst, en_s, en_bm, en_acs, o_tb_start, o_busy, o_done},
            8'b0100_0000);
      repeat (20) @(posedge clk);
      #1;
      check("no_done_on_abort", 32'(done_cnt - start_done), 0);
   endtask

   initial begin : driver
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);

      run_job(CODE_RATE_2, 1, 0, 1'b0, 1'b1, 16'hA5C3);
      run_job(CODE_RATE_2, 2, 0, 1'b0, 1'b0, 16'h0);
      run_job(CODE_RATE_3, 4, 0, 1'b0, 1'b0, 16'h0);
      run_job(CODE_RATE_2, 3, 10, 1'b0, 1'b0, 16'h0);
      abort_job();
      run_job(CODE_RATE_3, 3, 0, 1'b0, 1'b0, 16'h0);
      run_job(CODE_RATE_2, 5, 0, 1'b1, 1'b0, 16'h0);
      for (int j = 0; j < 8; j++)
         run_job(1'($urandom), int'($urandom_range(1, 12)), 0, 1'b0, 1'b0, 16'h0);
      run_job(CODE_RATE_3, 256, 0, 1'b0, 1'b0, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
